// File: rtl/uart_rx_core.sv
// UART receive front end: rx synchroniser, 16x oversampling tick generator and start/data/stop deframer.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx,
    output logic [DBIT-1:0]   dout,
    output logic              rx_done_tick,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [SW-1:0]     s;
    logic [NW-1:0]     n;
    logic [DBIT-1:0]   sh;
    logic [DVSR_W-1:0] tcnt;
    logic              tick;
    logic              rx_p0;
    logic              rx_s;
`ifdef UART_RX_PARITY_EN
    logic              par_bad;
`endif

    // Stage 0/1: two-flop synchroniser, reset to the idle-high line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // Oversampling tick; a count stranded above a lowered divisor wraps on the next clock
    assign tick = (tcnt == dvsr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tcnt <= '0;
        else if (tcnt >= dvsr)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    assign busy = (state != IDLE);

    // Deframer: strobes are registered, so they appear the cycle after the final stop tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            sh           <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == SW'(7)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == SW'(15)) begin
                            sh <= {rx_s, sh[DBIT-1:1]};
                            s  <= '0;
                            if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s == SW'(15)) begin
                            par_bad <= (^sh) ^ rx_s;
                            s       <= '0;
                            state   <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            dout  <= sh;
                            state <= IDLE;
                            if (rx_s)
                                rx_done_tick <= 1'b1;
                            else
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a bit-level line driver plus a frame-level reference model.
// Build with UART_RX_PARITY_EN defined to exercise the parity bit.
`timescale 1ns/1ps
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] dvsr = 11'd3;
    logic        rx = 1'b1;
    logic [7:0]  dout;
    logic        rx_done_tick, frame_err, parity_err, busy;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic       done;
        logic       ferr;
        logic       perr;
        longint     at;
    } ev_t;
    ev_t evq[$];

    uart_rx_core dut (
        .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .rx(rx), .dout(dout),
        .rx_done_tick(rx_done_tick), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe cycle is logged; a strobe held two cycles shows up as two entries
    always @(negedge clk)
        if (rx_done_tick || frame_err || parity_err)
            evq.push_back(ev_t'{d: dout, done: rx_done_tick, ferr: frame_err, perr: parity_err, at: cyc});

    task automatic hold(input int ticks);
        repeat (ticks * (int'(dvsr) + 1)) @(posedge clk);
        #1;
    endtask

    // A bad stop bit is low only through its sampling point, then the line returns high
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic pbit);
        rx = 1'b0; hold(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; hold(16);
        end
        if (PAR_EN) begin
            rx = pbit; hold(16);
        end
        if (stop_ok) begin
            rx = 1'b1; hold(16);
        end else begin
            rx = 1'b0; hold(12);
            rx = 1'b1; hold(4);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] b, input logic pbit);
        return PAR_EN && ((^b) ^ pbit);
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", rx_done_tick); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
        hold(4);
    endtask

    task automatic test_basic;
        longint t0, lat, nom;
        dvsr = 11'd3; evq.delete(); hold(16);
        nom = PAR_EN ? 672 : 608;
        t0 = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        hold(32);
        total++; if (evq.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", evq.size()); end
        if (evq.size() >= 1) begin
            lat = evq[0].at - t0;
            total++; if (evq[0].d !== 8'hA5) begin bad++; $display("FAIL basic_dout got=%h exp=a5", evq[0].d); end
            total++; if (evq[0].done !== 1'b1 || evq[0].ferr !== 1'b0) begin bad++; $display("FAIL basic_kind got=%b%b exp=10", evq[0].done, evq[0].ferr); end
            total++; if (lat < nom - 10 || lat > nom + 20) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d..%0d", lat, nom - 10, nom + 20); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_glitch;
        logic [7:0] old;
        dvsr = 11'd3; evq.delete(); old = dout;
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        repeat (8) @(posedge clk);
        #1;
        rx = 1'b1;
        hold(48);
        total++; if (evq.size() != 0) begin bad++; $display("FAIL glitch_strobes got=%0d exp=0", evq.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", busy); end
        total++; if (dout !== old) begin bad++; $display("FAIL glitch_dout got=%h exp=%h", dout, old); end
    endtask

    task automatic test_frame_err;
        dvsr = 11'd3; evq.delete();
        send_frame(8'h3C, 1'b0, ^8'h3C);
        hold(32);
        send_frame(8'h81, 1'b1, ^8'h81);
        hold(32);
        total++; if (evq.size() != 2) begin bad++; $display("FAIL ferr_count got=%0d exp=2", evq.size()); end
        if (evq.size() >= 2) begin
            total++; if (evq[0].ferr !== 1'b1 || evq[0].done !== 1'b0) begin bad++; $display("FAIL ferr_kind got=%b%b exp=01", evq[0].done, evq[0].ferr); end
            total++; if (evq[0].d !== 8'h3C) begin bad++; $display("FAIL ferr_dout got=%h exp=3c", evq[0].d); end
            total++; if (evq[1].done !== 1'b1 || evq[1].ferr !== 1'b0) begin bad++; $display("FAIL ferr_next_kind got=%b%b exp=10", evq[1].done, evq[1].ferr); end
            total++; if (evq[1].d !== 8'h81) begin bad++; $display("FAIL ferr_next_dout got=%h exp=81", evq[1].d); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] eb [2];
        eb[0] = 8'h00; eb[1] = 8'hFF;
        dvsr = 11'd0; evq.delete(); hold(16);
        send_frame(eb[0], 1'b1, ^eb[0]);
        send_frame(eb[1], 1'b1, ^eb[1]);
        hold(32);
        total++; if (evq.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", evq.size()); end
        for (int i = 0; i < 2 && i < evq.size(); i++) begin
            total++; if (evq[i].d !== eb[i]) begin bad++; $display("FAIL b2b_dout[%0d] got=%h exp=%h", i, evq[i].d, eb[i]); end
            total++; if (evq[i].done !== 1'b1 || evq[i].ferr !== 1'b0 || evq[i].perr !== 1'b0) begin bad++; $display("FAIL b2b_kind[%0d] got=%b%b%b exp=100", i, evq[i].done, evq[i].ferr, evq[i].perr); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        b = 8'h55;
        dvsr = 11'd3; evq.delete();
        rx = 1'b0; hold(16);
        for (int i = 0; i < 4; i++) begin
            rx = b[i]; hold(16);
        end
        rx = b[4]; hold(8);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        reset_n = 1'b0;
        #1;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL midrst_dout got=%h exp=00", dout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst_strobes got=%b%b exp=00", rx_done_tick, frame_err); end
        @(posedge clk);
        #1;
        reset_n = 1'b1; rx = 1'b1;
        hold(32);
        send_frame(8'h12, 1'b1, ^8'h12);
        hold(32);
        total++; if (evq.size() != 1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", evq.size()); end
        if (evq.size() >= 1) begin
            total++; if (evq[0].d !== 8'h12 || evq[0].done !== 1'b1) begin bad++; $display("FAIL midrst_next got=%h/%b exp=12/1", evq[0].d, evq[0].done); end
        end
    endtask

    task automatic test_parity;
        logic [7:0] b;
        logic       pb [2];
        b = 8'h07; pb[0] = 1'b1; pb[1] = 1'b0;
        dvsr = 11'd3; evq.delete();
        for (int i = 0; i < 2; i++) begin
            send_frame(b, 1'b1, pb[i]);
            hold(32);
        end
        total++; if (evq.size() != 2) begin bad++; $display("FAIL par_count got=%0d exp=2", evq.size()); end
        for (int i = 0; i < 2 && i < evq.size(); i++) begin
            total++; if (evq[i].done !== 1'b1 || evq[i].d !== b) begin bad++; $display("FAIL par_frame[%0d] got=%h/%b exp=07/1", i, evq[i].d, evq[i].done); end
            total++; if (evq[i].perr !== exp_perr(b, pb[i])) begin bad++; $display("FAIL par_err[%0d] got=%b exp=%b", i, evq[i].perr, exp_perr(b, pb[i])); end
        end
    endtask

    task automatic test_random;
        localparam int N = 6;
        logic [7:0] eb [N];
        logic       es [N];
        logic       ep [N];
        evq.delete();
        for (int i = 0; i < N; i++) begin
            eb[i] = 8'($urandom);
            es[i] = ($urandom_range(0, 3) != 0);
            ep[i] = 1'($urandom);
            dvsr  = 11'($urandom_range(0, 5));
            hold(8);
            send_frame(eb[i], es[i], ep[i]);
            hold(32);
        end
        total++; if (evq.size() != N) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", evq.size(), N); end
        for (int i = 0; i < N && i < evq.size(); i++) begin
            total++; if (evq[i].d !== eb[i]) begin bad++; $display("FAIL rand_dout[%0d] got=%h exp=%h", i, evq[i].d, eb[i]); end
            total++; if (evq[i].done !== es[i] || evq[i].ferr !== !es[i]) begin bad++; $display("FAIL rand_kind[%0d] got=%b%b exp=%b%b", i, evq[i].done, evq[i].ferr, es[i], !es[i]); end
            total++; if (evq[i].perr !== exp_perr(eb[i], ep[i])) begin bad++; $display("FAIL rand_perr[%0d] got=%b exp=%b", i, evq[i].perr, exp_perr(eb[i], ep[i])); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_reset_mid;
        test_parity;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
